// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: SPI mode-0 write master for the peripheral register bank.
// Buffers (addr,data) requests in a FIFO and shifts out {1,addr,data} MSB first.
module spi_cfg_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } state_t;

    logic [14:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, empty, push, pop;
    logic [14:0]   head;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [15:0]   shreg_q, shreg_d;
    logic          ncs_q, ncs_d;
    logic          sclk_q, sclk_d;
    logic          copi_q, copi_d;
    logic          done_q, done_d;
    logic          cnt_last;

    assign full      = (count_q == DEPTH);
    assign empty     = (count_q == '0);
    assign push      = req_valid && !full;
    assign head      = mem_q[rd_ptr_q];
    assign req_ready = !full;
    assign busy      = (state_q != IDLE) || !empty;
    assign done      = done_q;
    assign nCS       = ncs_q;
    assign SCLK      = sclk_q;
    assign COPI      = copi_q;
    assign cnt_last  = (cnt_q == DIV_LAST);

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= {req_addr, req_data};
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Frame sequencer: next state and next registered SPI pin values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ncs_d   = ncs_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = {1'b1, head};
                    state_d = SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                    copi_d  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_last) begin
                    state_d = SHIFT_HI;
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (cnt_last) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    bit_d  = bit_q + 5'd1;
                    if (bit_q == 5'd15) begin
                        state_d = HOLD;
                    end else begin
                        state_d = SHIFT_LO;
                        shreg_d = {shreg_q[14:0], 1'b0};
                        copi_d  = shreg_q[14];
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT_LO: begin
                if (cnt_last) begin
                    state_d = SHIFT_HI;
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (cnt_last) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state and glitch-free output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            done_q  <= done_d;
        end
    end

endmodule
